// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the endpoint data buffer and its arbiter.
//   DEPTH / AW   : buffer size in bytes and pointer width
//   arb_state_t  : arbiter fairness state (IDLE, LAST_USB, LAST_AHB)
//   d_mode_t     : transfer direction, matches protocol_controller's D_Mode
package usb_buffer_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAST_USB = 2'd1,
    LAST_AHB = 2'd2
  } arb_state_t;

  // D_MODE_OUT (1): host-to-endpoint, RX stores and AHB gets.
  // D_MODE_IN  (0): endpoint-to-host, AHB stores and TX gets.
  typedef enum logic {
    D_MODE_IN  = 1'b0,
    D_MODE_OUT = 1'b1
  } d_mode_t;

endpackage

// File: rtl/buffer_ram.sv
// Single-port DEPTH x 8 byte storage.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous reset of the read register only
//   i_we    : write enable, i_wdata stored at i_addr
//   i_re    : read enable, byte at i_addr registered into o_rdata
//   o_rdata : registered read byte, holds when i_re is low
module buffer_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/buffer_arbiter.sv
// Owns the endpoint data buffer and shares its single port between the USB
// side (RX store / TX get) and the AHB side (CPU store / get).
//   clk, rst, clear            : clock, sync reset, buffer flush
//   d_mode                     : 1 = RX stores + AHB gets, 0 = AHB stores + TX gets
//   *_req / *_ack              : byte request, combinational same-cycle grant
//   rx_wdata, ahb_wdata        : store data
//   rd_data, rd_valid          : read byte, valid the cycle after a get grant
//   buffer_occupancy/empty/full: registered fill level
//   overflow_err/underflow_err : sticky until clear or rst
module buffer_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = usb_buffer_pkg::DEPTH,
  parameter int unsigned AW    = usb_buffer_pkg::AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_mode,
  input  logic        rx_store_req,
  input  logic [7:0]  rx_wdata,
  input  logic        tx_get_req,
  input  logic        ahb_store_req,
  input  logic [7:0]  ahb_wdata,
  input  logic        ahb_get_req,
  output logic        rx_store_ack,
  output logic        tx_get_ack,
  output logic        ahb_store_ack,
  output logic        ahb_get_ack,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] buffer_occupancy,
  output logic        buffer_empty,
  output logic        buffer_full,
  output logic        overflow_err,
  output logic        underflow_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;
  arb_state_t    r_state;
  logic          r_ovf;
  logic          r_unf;
  logic          r_rd_valid;

  logic          w_block;
  logic          w_rx_dir;
  logic          w_full;
  logic          w_empty;
  logic          w_usb_req;
  logic          w_ahb_req;
  logic          w_usb_ok;
  logic          w_ahb_ok;
  logic          w_grant_usb;
  logic          w_grant_ahb;
  logic          w_store;
  logic          w_get;
  logic          w_ovf_hit;
  logic          w_unf_hit;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata;

  always_comb begin
    w_block   = rst | clear;
    w_rx_dir  = (d_mode_t'(d_mode) == D_MODE_OUT);
    w_full    = (r_occ == FULL_CNT);
    w_empty   = (r_occ == '0);
    // Only the legal pair for the current direction is ever looked at.
    w_usb_req = w_rx_dir ? rx_store_req : tx_get_req;
    w_ahb_req = w_rx_dir ? ahb_get_req  : ahb_store_req;
    // Each side is eligible only if its own direction can proceed, so a full
    // buffer never starves the draining side.
    w_usb_ok  = w_usb_req & ~w_block & (w_rx_dir ? ~w_full  : ~w_empty);
    w_ahb_ok  = w_ahb_req & ~w_block & (w_rx_dir ? ~w_empty : ~w_full);
    // AHB wins a tie only right after a USB grant; otherwise USB wins.
    w_grant_ahb = w_ahb_ok & (~w_usb_ok | (r_state == LAST_USB));
    w_grant_usb = w_usb_ok & ~w_grant_ahb;
    w_store   = w_rx_dir ? w_grant_usb : w_grant_ahb;
    w_get     = w_rx_dir ? w_grant_ahb : w_grant_usb;
    w_ovf_hit = ~w_block & w_full  & (w_rx_dir ? rx_store_req : ahb_store_req);
    w_unf_hit = ~w_block & w_empty & (w_rx_dir ? ahb_get_req  : tx_get_req);
    w_addr    = w_store ? r_wptr : r_rptr;
    w_wdata   = w_rx_dir ? rx_wdata : ahb_wdata;

    rx_store_ack  = w_rx_dir  & w_grant_usb;
    tx_get_ack    = ~w_rx_dir & w_grant_usb;
    ahb_store_ack = ~w_rx_dir & w_grant_ahb;
    ahb_get_ack   = w_rx_dir  & w_grant_ahb;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_state    <= IDLE;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_grant_usb)      r_state <= LAST_USB;
      else if (w_grant_ahb) r_state <= LAST_AHB;
      else                  r_state <= IDLE;
      // Store and get are mutually exclusive, so occupancy moves by at most one.
      if (w_store) begin
        r_wptr <= r_wptr + 1'b1;
        r_occ  <= r_occ + 1'b1;
      end else if (w_get) begin
        r_rptr <= r_rptr + 1'b1;
        r_occ  <= r_occ - 1'b1;
      end
      r_ovf      <= r_ovf | w_ovf_hit;
      r_unf      <= r_unf | w_unf_hit;
      r_rd_valid <= w_get;
    end
  end

  buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_store),
    .i_re    (w_get),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (rd_data)
  );

  assign rd_valid         = r_rd_valid;
  assign buffer_occupancy = r_occ;
  assign buffer_empty     = w_empty;
  assign buffer_full      = w_full;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule
